// File: rtl/rv32i_fetch_pkg.sv
// Shared constants and helpers for the RV32I instruction fetch stage.
package rv32i_fetch_pkg;

   localparam int          RV32I_INSTR_WIDTH = 32;
   localparam logic [31:0] RV32I_NOP         = 32'h0000_0013;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/rv32i_fetch_buf.sv
// Two-entry skid FIFO holding fetched {pc, instr} pairs while decode is stalled.
module rv32i_fetch_buf
   import rv32i_fetch_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [31:0]                  push_pc,
   input  logic [RV32I_INSTR_WIDTH-1:0] push_instr,
   input  logic                         pop,
   output logic [31:0]                  head_pc,
   output logic [RV32I_INSTR_WIDTH-1:0] head_instr,
   output logic [1:0]                   count,
   output logic                         empty,
   output logic                         full
);

   logic [31:0]                  pc_mem    [2];
   logic [RV32I_INSTR_WIDTH-1:0] instr_mem [2];
   logic                         wr_ptr;
   logic                         rd_ptr;
   logic [1:0]                   count_q;
   logic                         do_push;
   logic                         do_pop;

   assign empty      = (count_q == 2'd0);
   assign full       = (count_q == 2'd2);
   assign count      = count_q;
   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

   // A push into a full buffer is only taken when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: owns the fetch PC, issues word reads and feeds decode through a skid buffer.
module rv32i_fetch
   import rv32i_fetch_pkg::*;
#(
   parameter logic [31:0] RV32I_RESET_VECTOR    = 32'h0000_0000,
   parameter int          RV32I_IMEM_ADDR_WIDTH = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             update_pc,
   input  logic [31:0]                      new_pc,
   output logic [RV32I_IMEM_ADDR_WIDTH-1:0] iaddress,
   output logic                             iread,
   input  logic                             iwaitreq,
   input  logic [RV32I_INSTR_WIDTH-1:0]     ireaddata,
   output logic [RV32I_INSTR_WIDTH-1:0]     instr,
   output logic [31:0]                      pc,
   output logic                             instr_misaligned
);

   logic [31:0]                  fpc_p0;
   logic                         vld_p1;
   logic                         drop_p1;
   logic [31:0]                  ret_pc_p1;
   logic [RV32I_INSTR_WIDTH-1:0] instr_q;
   logic [31:0]                  pc_q;
   logic                         mis_q;

   logic                         accept;
   logic                         ret_vld;
   logic [1:0]                   occupancy;
   logic                         buf_push;
   logic                         buf_pop;
   logic [31:0]                  buf_head_pc;
   logic [RV32I_INSTR_WIDTH-1:0] buf_head_instr;
   logic [1:0]                   buf_count;
   logic                         buf_empty;
   logic                         buf_full;

   // Credits: words buffered plus the word in flight must leave room for one more.
   assign occupancy = buf_count + {1'b0, vld_p1};
   assign iread     = ~reset & ~buf_full & (occupancy < 2'd2);
   assign iaddress  = fpc_p0[RV32I_IMEM_ADDR_WIDTH+1:2];
   assign accept    = iread & ~iwaitreq;

   assign ret_vld  = vld_p1 & ~drop_p1;
   assign buf_pop  = ~stall & ~buf_empty;
   assign buf_push = ret_vld & (stall | ~buf_empty);

   rv32i_fetch_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (update_pc),
      .push       (buf_push),
      .push_pc    (ret_pc_p1),
      .push_instr (ireaddata),
      .pop        (buf_pop),
      .head_pc    (buf_head_pc),
      .head_instr (buf_head_instr),
      .count      (buf_count),
      .empty      (buf_empty),
      .full       (buf_full)
   );

   // Issue stage (p0) -> memory return stage (p1)
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc_p0  <= RV32I_RESET_VECTOR;
         vld_p1  <= 1'b0;
         drop_p1 <= 1'b0;
      end else begin
         vld_p1  <= accept;
         drop_p1 <= update_pc;
         if (update_pc)
            fpc_p0 <= align_word(new_pc);
         else if (accept)
            fpc_p0 <= fpc_p0 + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) ret_pc_p1 <= fpc_p0;
   end

   // Return stage (p1) -> decode-facing output register; the buffer head is always older than the bypass word.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= RV32I_NOP;
         pc_q    <= RV32I_RESET_VECTOR;
         mis_q   <= 1'b0;
      end else begin
         mis_q <= update_pc & (new_pc[1:0] != 2'b00);
         if (update_pc) begin
            instr_q <= RV32I_NOP;
            pc_q    <= align_word(new_pc);
         end else if (!stall) begin
            if (!buf_empty) begin
               instr_q <= buf_head_instr;
               pc_q    <= buf_head_pc;
            end else if (ret_vld) begin
               instr_q <= ireaddata;
               pc_q    <= ret_pc_p1;
            end else begin
               instr_q <= RV32I_NOP;
            end
         end
      end
   end

   assign instr            = instr_q;
   assign pc               = pc_q;
   assign instr_misaligned = mis_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: queue-based fetch model plus directed literal checks and random stimulus.
module tb_rv32i_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        update_pc = 1'b0;
   logic [31:0] new_pc = 32'h0;
   logic        iwaitreq = 1'b0;
   logic [31:0] ireaddata = 32'h0;
   logic [11:0] iaddress;
   logic        iread;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_misaligned;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv32i_fetch #(
      .RV32I_RESET_VECTOR    (32'h0000_0000),
      .RV32I_IMEM_ADDR_WIDTH (12)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .update_pc        (update_pc),
      .new_pc           (new_pc),
      .iaddress         (iaddress),
      .iread            (iread),
      .iwaitreq         (iwaitreq),
      .ireaddata        (ireaddata),
      .instr            (instr),
      .pc               (pc),
      .instr_misaligned (instr_misaligned)
   );

   // Memory word i holds the value i; outside a valid return the data bus carries junk.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {20'h0, a[13:2]};
   endfunction

   always @(posedge clk) begin
      if (iread && !iwaitreq) ireaddata <= {20'h0, iaddress};
      else                    ireaddata <= {1'b1, 31'($urandom)};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched-but-not-yet-presented addresses.
   logic [31:0] m_fpc;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_q[$];
   bit          m_live = 0;

   always @(posedge clk) begin
      bit acc;
      if (reset) begin
         m_fpc   = 32'h0;
         m_instr = NOP;
         m_pc    = 32'h0;
         m_mis   = 1'b0;
         m_q.delete();
         m_live  = 1;
      end else if (update_pc) begin
         m_fpc   = {new_pc[31:2], 2'b00};
         m_instr = NOP;
         m_pc    = m_fpc;
         m_mis   = (new_pc[1:0] != 2'b00);
         m_q.delete();
      end else begin
         acc   = (m_q.size() < 2) && !iwaitreq;
         m_mis = 1'b0;
         if (!stall) begin
            if (m_q.size() > 0) begin
               m_pc    = m_q.pop_front();
               m_instr = mem_word(m_pc);
            end else begin
               m_instr = NOP;
            end
         end
         if (acc) begin
            m_q.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      logic exp_rd;
      if (m_live) begin
         exp_rd = !reset && (m_q.size() < 2);
         chk("model_iread", {31'b0, iread}, {31'b0, exp_rd});
         if (exp_rd) chk("model_iaddress", {20'h0, iaddress}, {20'h0, m_fpc[13:2]});
         chk("model_instr", instr, m_instr);
         chk("model_pc", pc, m_pc);
         chk("model_misaligned", {31'b0, instr_misaligned}, {31'b0, m_mis});
      end
   end

   task automatic cyc(input bit r, input bit s, input bit u, input logic [31:0] np, input bit w);
      @(negedge clk);
      #1;
      reset     = r;
      stall     = s;
      update_pc = u;
      new_pc    = np;
      iwaitreq  = w;
   endtask

   initial begin
      repeat (3) cyc(1, 0, 1, 32'h40, 0);
      chk("reset_instr", instr, NOP);
      chk("reset_pc", pc, 32'h0);
      chk("reset_iread", {31'b0, iread}, 32'h0);
      chk("reset_mis", {31'b0, instr_misaligned}, 32'h0);

      // Streaming from the reset vector
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("stream0_instr", instr, 32'd0);
      chk("stream0_pc", pc, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("stream1_instr", instr, 32'd1);
      chk("stream1_pc", pc, 32'h4);
      cyc(0, 0, 0, 0, 0);
      chk("stream2_instr", instr, 32'd2);
      chk("stream2_pc", pc, 32'h8);

      // Four stalled edges
      cyc(0, 1, 0, 0, 0);
      chk("prestall_pc", pc, 32'hC);
      repeat (3) begin
         cyc(0, 1, 0, 0, 0);
         chk("stall_pc", pc, 32'hC);
         chk("stall_instr", instr, 32'd3);
      end
      cyc(0, 0, 0, 0, 0);
      chk("stall_pc4", pc, 32'hC);
      chk("stall_full_iread", {31'b0, iread}, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("unstall_pc", pc, 32'h10);
      chk("unstall_instr", instr, 32'd4);
      cyc(0, 0, 0, 0, 0);
      chk("unstall_pc2", pc, 32'h14);

      // Redirect with a read in flight
      cyc(0, 0, 1, 32'h100, 0);
      cyc(0, 0, 0, 0, 0);
      chk("redir_n1_instr", instr, NOP);
      chk("redir_n1_pc", pc, 32'h100);
      cyc(0, 0, 0, 0, 0);
      chk("redir_n2_instr", instr, NOP);
      cyc(0, 0, 0, 0, 0);
      chk("redir_n3_instr", instr, 32'h40);
      chk("redir_n3_pc", pc, 32'h100);
      cyc(0, 0, 0, 0, 0);
      chk("redir_n4_pc", pc, 32'h104);

      // Misaligned redirect
      cyc(0, 0, 1, 32'h102, 0);
      cyc(0, 0, 0, 0, 0);
      chk("mis_pulse", {31'b0, instr_misaligned}, 32'h1);
      chk("mis_pc", pc, 32'h100);
      cyc(0, 0, 0, 0, 0);
      chk("mis_clear", {31'b0, instr_misaligned}, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("mis_instr", instr, 32'h40);

      // Memory wait states
      cyc(0, 0, 0, 0, 1);
      chk("wait1_addr", {20'h0, iaddress}, 32'h43);
      chk("wait1_instr", instr, 32'h41);
      cyc(0, 0, 0, 0, 1);
      chk("wait2_addr", {20'h0, iaddress}, 32'h43);
      chk("wait2_instr", instr, 32'h42);
      cyc(0, 0, 0, 0, 1);
      chk("wait3_addr", {20'h0, iaddress}, 32'h43);
      chk("wait3_instr", instr, NOP);
      chk("wait3_pc", pc, 32'h108);
      cyc(0, 0, 0, 0, 0);
      chk("wait4_addr", {20'h0, iaddress}, 32'h43);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("resume_instr", instr, 32'h43);
      chk("resume_pc", pc, 32'h10C);

      // Redirect together with stall while the buffer is full
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("full_iread", {31'b0, iread}, 32'h0);
      cyc(0, 1, 1, 32'h200, 0);
      cyc(0, 0, 0, 0, 0);
      chk("stallredir_instr", instr, NOP);
      chk("stallredir_pc", pc, 32'h200);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("stallredir_tgt", instr, 32'h80);

      // Fetch PC wrap
      cyc(0, 0, 1, 32'hFFFF_FFF8, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("wrap_pc0", pc, 32'hFFFF_FFF8);
      chk("wrap_instr0", instr, 32'hFFE);
      cyc(0, 0, 0, 0, 0);
      chk("wrap_pc1", pc, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 0);
      chk("wrap_pc2", pc, 32'h0);
      chk("wrap_instr2", instr, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         logic [31:0] tgt;
         r   = $urandom_range(0, 999);
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         cyc(r < 5, $urandom_range(0, 9) < 3, (r >= 5) && (r < 40), tgt, $urandom_range(0, 3) == 0);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
